aes_result_collector: RTL and testbench

AES_RESULT_COLLECTOR -- requirements
Module: aes_result_collector

---
 rtl/aes_result_collector_if.sv | 28 ++
 rtl/aes_result_collector.sv | 145 ++++++++++++++
 tb/tb_aes_result_collector.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_result_collector_if.sv
// Collector-side bundle: AES encoder/decoder result inputs, the record stream toward the output pipe,
// and the status flags. master = environment/transactor side, slave = the collector.
interface aes_result_collector_if #(
  parameter int SEQ_W = 16
);
  logic               flush;
  logic [127:0]       encryptData;
  logic               encryptValid;
  logic [127:0]       plainData;
  logic               plainValid;
  logic               eom;
  logic               outValid;
  logic               outReady;
  logic [SEQ_W+257:0] outData;
  logic               overflow;
  logic [15:0]        dropCount;
  logic               done;

  modport master (
    output flush, encryptData, encryptValid, plainData, plainValid, eom, outReady,
    input  outValid, outData, overflow, dropCount, done
  );

  modport slave (
    input  flush, encryptData, encryptValid, plainData, plainValid, eom, outReady,
    output outValid, outData, overflow, dropCount, done
  );
endinterface

// File: rtl/aes_result_collector.sv
// Sequence-tagged AES result FIFO; records appear 1 cycle after push, stall on outReady=0, drop when full.
// Optional saturating drop counter under AES_COLLECT_DROPCOUNT_EN (dropCount reads 0 when undefined).
module aes_result_collector #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input logic                   clock,
  input logic                   reset,
  aes_result_collector_if.slave bus
);
  localparam int REC_W    = SEQ_W + 258;
  localparam int AW       = $clog2(DEPTH);
  localparam int NUM_IDLE = 16;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t             state;
  state_t             nextState;
  logic [REC_W-1:0]   mem [DEPTH];
  logic [AW-1:0]      wrPtr;
  logic [AW-1:0]      rdPtr;
  logic [AW:0]        count;
  logic [SEQ_W-1:0]   seqCnt;
  logic [4:0]         idleCnt;
  logic               overflowReg;
  logic [15:0]        dropCnt;

  logic               pushReq;
  logic               acceptState;
  logic               full;
  logic               outValidInt;
  logic               popDo;
  logic               pushDo;
  logic               fullDrop;
  logic               dropDo;
  logic               idleCycle;
  logic [REC_W-1:0]   record;

  assign pushReq     = bus.encryptValid | bus.plainValid;
  assign acceptState = (state == COLLECT) || (state == DRAIN);
  assign full        = (count == (AW+1)'(DEPTH));
  assign outValidInt = (count != '0) && (state != DONE);
  assign popDo       = outValidInt && bus.outReady;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pushDo      = pushReq && acceptState && (!full || popDo);
  assign fullDrop    = pushReq && acceptState && full && !popDo;
  assign dropDo      = fullDrop || (pushReq && (state == DONE));
  assign idleCycle   = (state == DRAIN) && (count == '0) && !pushReq;

  assign record = {seqCnt,
                   bus.encryptValid ? bus.encryptData : 128'd0,
                   bus.plainValid   ? bus.plainData   : 128'd0,
                   bus.encryptValid, bus.plainValid};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (bus.flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    nextState = COLLECT;
        COLLECT: if (bus.eom) nextState = DRAIN;
        DRAIN:   if (idleCycle && (idleCnt == 5'(NUM_IDLE - 1))) nextState = DONE;
        DONE:    nextState = DONE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      seqCnt      <= '0;
      idleCnt     <= '0;
      overflowReg <= 1'b0;
    end else if (bus.flush) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      seqCnt      <= '0;
      idleCnt     <= '0;
      overflowReg <= 1'b0;
    end else begin
      if (pushDo) begin
        wrPtr  <= wrPtr + AW'(1);
        seqCnt <= seqCnt + SEQ_W'(1);
      end
      if (popDo) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({pushDo, popDo})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (fullDrop) begin
        overflowReg <= 1'b1;
      end
      if (idleCycle) begin
        idleCnt <= idleCnt + 5'd1;
      end else begin
        idleCnt <= '0;
      end
    end
  end

  // Storage is not reset; count gating keeps stale entries invisible.
  always_ff @(posedge clock) begin
    if (pushDo && !bus.flush) begin
      mem[wrPtr] <= record;
    end
  end

`ifdef AES_COLLECT_DROPCOUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dropCnt <= '0;
    end else if (bus.flush) begin
      dropCnt <= '0;
    end else if (dropDo && (dropCnt != 16'hFFFF)) begin
      dropCnt <= dropCnt + 16'd1;
    end
  end
`else
  logic unusedDrop;
  assign unusedDrop = dropDo;
  assign dropCnt    = 16'd0;
`endif

  assign bus.outValid  = outValidInt;
  assign bus.outData   = outValidInt ? mem[rdPtr] : '0;
  assign bus.overflow  = overflowReg;
  assign bus.dropCount = dropCnt;
  assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_aes_result_collector.sv
// Directed bench for aes_result_collector: reset, ordering, overflow, stall hold, drain/done, async reset.
module tb_aes_result_collector;
  localparam int SEQ_W = 16;
  localparam int REC_W = SEQ_W + 258;
  typedef logic [REC_W-1:0] val_t;

`ifdef AES_COLLECT_DROPCOUNT_EN
  localparam int DROP_ON = 1;
`else
  localparam int DROP_ON = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checkCount = 0;
  int   errorCount = 0;

  aes_result_collector_if #(.SEQ_W(SEQ_W)) bus ();

  aes_result_collector #(.DEPTH(8), .SEQ_W(SEQ_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic checkVal(input string tag, input val_t got, input val_t exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doFlush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
  endtask

  function automatic val_t seqOf(input val_t d);
    return val_t'(d[REC_W-1 -: SEQ_W]);
  endfunction

  function automatic val_t encOf(input val_t d);
    return val_t'(d[257:130]);
  endfunction

  function automatic val_t plainOf(input val_t d);
    return val_t'(d[129:2]);
  endfunction

  logic [127:0] vec;
  val_t         expRec;
  val_t         heldDat;
  logic         held;
  logic         pushed;
  int           pushIdx;
  int           rxCnt;
  int           cyc;
  int           pops;
  int           idleWait;

  initial begin
    bus.flush        = 1'b0;
    bus.encryptData  = '0;
    bus.encryptValid = 1'b0;
    bus.plainData    = '0;
    bus.plainValid   = 1'b0;
    bus.eom          = 1'b0;
    bus.outReady     = 1'b0;
    vec              = 128'h3925841d02dc09fbdc118597196a0b32;

    #2 reset = 1'b0;
    #10;
    checkVal("rst_outValid",  val_t'(bus.outValid),  val_t'(0));
    checkVal("rst_outData",   bus.outData,           val_t'(0));
    checkVal("rst_overflow",  val_t'(bus.overflow),  val_t'(0));
    checkVal("rst_dropCount", val_t'(bus.dropCount), val_t'(0));
    checkVal("rst_done",      val_t'(bus.done),      val_t'(0));

    // First edge after release is IDLE: this push must vanish without counting.
    @(negedge clock);
    reset            = 1'b1;
    bus.encryptValid = 1'b1;
    bus.encryptData  = 128'h1111;
    tick();
    checkVal("idle_ignore_valid", val_t'(bus.outValid),  val_t'(0));
    checkVal("idle_ignore_drop",  val_t'(bus.dropCount), val_t'(0));

    bus.encryptData = vec;
    bus.plainData   = 128'hdeadbeef;
    bus.plainValid  = 1'b0;
    bus.outReady    = 1'b1;
    checkVal("no_bypass", val_t'(bus.outValid), val_t'(0));
    tick();
    bus.encryptValid = 1'b0;
    expRec = {16'd0, vec, 128'd0, 2'b10};
    checkVal("single_valid", val_t'(bus.outValid), val_t'(1));
    checkVal("single_rec",   bus.outData,          expRec);
    tick();
    checkVal("single_popped", val_t'(bus.outValid), val_t'(0));

    // Overflow: ten pushes into eight slots with the consumer stalled.
    doFlush();
    checkVal("flush_seq_clear", val_t'(bus.outValid), val_t'(0));
    bus.outReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.plainValid = 1'b1;
      bus.plainData  = 128'(i + 32'h100);
      tick();
    end
    bus.plainValid = 1'b0;
    checkVal("ovf_flag",  val_t'(bus.overflow),  val_t'(1));
    checkVal("ovf_drops", val_t'(bus.dropCount), val_t'(DROP_ON * 2));
    bus.outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkVal("ovf_drain_valid", val_t'(bus.outValid), val_t'(1));
      checkVal("ovf_drain_seq",   seqOf(bus.outData),   val_t'(i));
      checkVal("ovf_drain_plain", plainOf(bus.outData), val_t'(i + 32'h100));
      tick();
    end
    checkVal("ovf_empty", val_t'(bus.outValid), val_t'(0));

    // Full FIFO with simultaneous push and pop keeps eight entries, no overflow.
    doFlush();
    bus.outReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.encryptValid = 1'b1;
      bus.encryptData  = 128'(i);
      tick();
    end
    bus.encryptData = 128'd8;
    bus.outReady    = 1'b1;
    tick();
    bus.encryptValid = 1'b0;
    bus.outReady     = 1'b0;
    checkVal("full_pp_overflow", val_t'(bus.overflow), val_t'(0));
    bus.outReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checkVal("full_pp_seq", seqOf(bus.outData), val_t'(i));
      tick();
    end
    checkVal("full_pp_empty", val_t'(bus.outValid), val_t'(0));

    // Consumer toggles ready every cycle; held records must not change.
    doFlush();
    pushIdx = 0;
    rxCnt   = 0;
    cyc     = 0;
    held    = 1'b0;
    heldDat = '0;
    while (rxCnt < 20 && cyc < 200) begin
      bus.encryptValid = ((cyc % 2) == 1) && (pushIdx < 20);
      bus.encryptData  = 128'(pushIdx + 32'hA0);
      bus.outReady     = ((cyc % 2) == 1);
      if (bus.outValid) begin
        if (held) checkVal("stall_hold", bus.outData, heldDat);
        if (bus.outReady) begin
          checkVal("toggle_seq", seqOf(bus.outData), val_t'(rxCnt));
          checkVal("toggle_enc", encOf(bus.outData), val_t'(rxCnt + 32'hA0));
          rxCnt++;
          held = 1'b0;
        end else begin
          held    = 1'b1;
          heldDat = bus.outData;
        end
      end else begin
        held = 1'b0;
      end
      pushed = bus.encryptValid;
      tick();
      if (pushed) pushIdx++;
      cyc++;
    end
    bus.encryptValid = 1'b0;
    checkVal("toggle_rx_count", val_t'(rxCnt),        val_t'(20));
    checkVal("toggle_overflow", val_t'(bus.overflow), val_t'(0));

    // eom with three queued: drain, then done after sixteen idle cycles.
    doFlush();
    bus.outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.plainValid = 1'b1;
      bus.plainData  = 128'(i);
      tick();
    end
    bus.plainValid = 1'b0;
    bus.eom        = 1'b1;
    bus.outReady   = 1'b1;
    pops = 0;
    while (bus.outValid && pops < 20) begin
      tick();
      pops++;
    end
    checkVal("eom_pops", val_t'(pops), val_t'(3));
    idleWait = 0;
    while (!bus.done && idleWait < 40) begin
      tick();
      idleWait++;
    end
    checkVal("done_idle_cycles", val_t'(idleWait), val_t'(16));
    bus.encryptValid = 1'b1;
    bus.encryptData  = 128'h55;
    tick();
    bus.encryptValid = 1'b0;
    tick();
    checkVal("done_no_output", val_t'(bus.outValid),  val_t'(0));
    checkVal("done_sticky",    val_t'(bus.done),      val_t'(1));
    checkVal("done_drop",      val_t'(bus.dropCount), val_t'(DROP_ON));
    bus.eom = 1'b0;
    doFlush();
    checkVal("flush_clears_done", val_t'(bus.done), val_t'(0));

    // Asynchronous reset in the middle of DRAIN with five queued.
    bus.outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.encryptValid = 1'b1;
      bus.encryptData  = 128'(i);
      tick();
    end
    bus.encryptValid = 1'b0;
    bus.eom          = 1'b1;
    tick();
    checkVal("pre_reset_valid", val_t'(bus.outValid), val_t'(1));
    #3 reset = 1'b0;
    #1;
    checkVal("async_rst_valid", val_t'(bus.outValid), val_t'(0));
    checkVal("async_rst_data",  bus.outData,          val_t'(0));
    checkVal("async_rst_done",  val_t'(bus.done),     val_t'(0));
    @(negedge clock);
    reset        = 1'b1;
    bus.eom      = 1'b0;
    bus.outReady = 1'b1;
    tick();
    checkVal("post_rst_no_pulse", val_t'(bus.outValid), val_t'(0));
    bus.encryptValid = 1'b1;
    bus.encryptData  = vec;
    tick();
    bus.encryptValid = 1'b0;
    bus.outReady     = 1'b0;
    checkVal("post_rst_collect", val_t'(bus.outValid), val_t'(1));
    checkVal("post_rst_seq",     seqOf(bus.outData),   val_t'(0));

    // Flush beats a simultaneous push and pop.
    bus.flush        = 1'b1;
    bus.encryptValid = 1'b1;
    bus.outReady     = 1'b1;
    tick();
    bus.flush        = 1'b0;
    bus.encryptValid = 1'b0;
    checkVal("flush_wins", val_t'(bus.outValid), val_t'(0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
